// File: rtl/bypass_net.sv
// -----------------------------------------------------------------------------
// bypass_net
//
// Operand bypass network. It keeps a short shift history of register
// writebacks so that operand lookups can pick up results that are not yet
// readable from the register file. Stage 0 is the live writeback bus, which
// gives a combinational same-cycle forward. Stages 1..DEPTH hold the
// writebacks of 1..DEPTH cycles ago. The youngest stage wins. Within a stage,
// the highest-numbered writeback port wins.
//
// Parameters
//   WB_WIDTH  writeback ports per cycle
//   RD_PORTS  operand lookup ports
//   DEPTH     registered history stages kept after the writeback cycle (1..4)
//   IDX_W     physical register index width
//   DATA_W    data width
//
// Ports
//   clk          single clock; all state updates on its rising edge
//   rst          asynchronous active-low reset
//   i_clr        synchronous invalidate of history older than the next stage 1
//   i_wb_vld     per-port writeback valid
//   i_wb_idx     per-port writeback physical register index
//   i_wb_data    per-port writeback data
//   i_rd_req     per-port lookup request
//   i_rd_idx     per-port lookup physical register index
//   o_rd_vld     lookup hit
//   o_rd_data    forwarded data (0 on miss)
//   o_rd_stage   age of the hit: 0 = current cycle, k = k cycles ago
//   o_multi_hit  sticky flag: two entries of one stage matched a lookup
// -----------------------------------------------------------------------------
module bypass_net #(
    parameter int WB_WIDTH = 4,
    parameter int RD_PORTS = 6,
    parameter int DEPTH    = 2,
    parameter int IDX_W    = 6,
    parameter int DATA_W   = 64
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_clr,
    input  logic [WB_WIDTH-1:0]                       i_wb_vld,
    input  logic [WB_WIDTH-1:0][IDX_W-1:0]            i_wb_idx,
    input  logic [WB_WIDTH-1:0][DATA_W-1:0]           i_wb_data,
    input  logic [RD_PORTS-1:0]                       i_rd_req,
    input  logic [RD_PORTS-1:0][IDX_W-1:0]            i_rd_idx,
    output logic [RD_PORTS-1:0]                       o_rd_vld,
    output logic [RD_PORTS-1:0][DATA_W-1:0]           o_rd_data,
    output logic [RD_PORTS-1:0][$clog2(DEPTH+1)-1:0]  o_rd_stage,
    output logic                                      o_multi_hit
);

    localparam int STG_W = $clog2(DEPTH+1);

    // Registered history, stage 1 (youngest) .. DEPTH (oldest).
    logic [DEPTH:1][WB_WIDTH-1:0]             r_vld;
    logic [DEPTH:1][WB_WIDTH-1:0][IDX_W-1:0]  r_idx;
    logic [DEPTH:1][WB_WIDTH-1:0][DATA_W-1:0] r_data;
    logic                                     r_multi_hit;

    // Full lookup view: stage 0 is the live writeback bus.
    logic [DEPTH:0][WB_WIDTH-1:0]             w_vld;
    logic [DEPTH:0][WB_WIDTH-1:0][IDX_W-1:0]  w_idx;
    logic [DEPTH:0][WB_WIDTH-1:0][DATA_W-1:0] w_data;
    logic [WB_WIDTH-1:0]                      w_match;
    logic [RD_PORTS-1:0]                      w_dup;

    assign w_vld  = {r_vld,  i_wb_vld};
    assign w_idx  = {r_idx,  i_wb_idx};
    assign w_data = {r_data, i_wb_data};

    // Valid bits and the sticky flag are the only state that needs reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld       <= '0;
            r_multi_hit <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old
            // value of its neighbour, which is what makes this a shift chain.
            r_vld[1] <= i_wb_vld;
            for (int k = 2; k <= DEPTH; k++) begin
                // A clear kills everything older than this cycle's writebacks.
                r_vld[k] <= i_clr ? '0 : r_vld[k-1];
            end
            r_multi_hit <= r_multi_hit | (|w_dup);
        end
    end

    // NOTE: idx/data payload has no reset; an entry is qualified only by its
    // valid bit, so resetting the payload would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        r_idx[1]  <= i_wb_idx;
        r_data[1] <= i_wb_data;
        for (int k = 2; k <= DEPTH; k++) begin
            r_idx[k]  <= r_idx[k-1];
            r_data[k] <= r_data[k-1];
        end
    end

    // Lookup. The stages are scanned oldest to youngest and the ports lowest to
    // highest, so the last match written wins. That gives youngest-stage
    // priority, and within a stage it gives highest-port priority.
    always_comb begin
        // NOTE: every output is defaulted first, so no path leaves a value
        // unassigned and no latch is inferred.
        o_rd_vld   = '0;
        o_rd_data  = '0;
        o_rd_stage = '0;
        w_dup      = '0;
        w_match    = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
            if (i_rd_req[r]) begin
                for (int s = DEPTH; s >= 0; s--) begin
                    for (int p = 0; p < WB_WIDTH; p++) begin
                        w_match[p] = w_vld[s][p] && (w_idx[s][p] == i_rd_idx[r]);
                    end
                    for (int p = 0; p < WB_WIDTH; p++) begin
                        if (w_match[p]) begin
                            o_rd_vld[r]   = 1'b1;
                            o_rd_data[r]  = w_data[s][p];
                            o_rd_stage[r] = STG_W'(s);
                        end
                    end
                    // Two writers of one register in one stage point to an upstream bug.
                    if ($countones(w_match) > 1) begin
                        w_dup[r] = 1'b1;
                    end
                end
            end
        end
    end

    assign o_multi_hit = r_multi_hit;

endmodule

// File: tb/tb_bypass_net.sv
// -----------------------------------------------------------------------------
// tb_bypass_net
//
// Bench for bypass_net. The reference model keeps a list of writeback events
// stamped with their cycle. Lookups pick the youngest event whose age is at
// most DEPTH, and break ties by the highest port. A clear drops the events
// born before the clear cycle. A reset drops all events.
// -----------------------------------------------------------------------------
module tb_bypass_net;

    localparam int WB     = 4;
    localparam int RD     = 6;
    localparam int DEPTH  = 2;
    localparam int IDX_W  = 6;
    localparam int DATA_W = 64;
    localparam int STG_W  = $clog2(DEPTH+1);

    logic                             clk = 1'b0;
    logic                             rst;
    logic                             i_clr;
    logic [WB-1:0]                    i_wb_vld;
    logic [WB-1:0][IDX_W-1:0]         i_wb_idx;
    logic [WB-1:0][DATA_W-1:0]        i_wb_data;
    logic [RD-1:0]                    i_rd_req;
    logic [RD-1:0][IDX_W-1:0]         i_rd_idx;
    logic [RD-1:0]                    o_rd_vld;
    logic [RD-1:0][DATA_W-1:0]        o_rd_data;
    logic [RD-1:0][STG_W-1:0]         o_rd_stage;
    logic                             o_multi_hit;

    bypass_net #(
        .WB_WIDTH (WB),
        .RD_PORTS (RD),
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (i_clr),
        .i_wb_vld    (i_wb_vld),
        .i_wb_idx    (i_wb_idx),
        .i_wb_data   (i_wb_data),
        .i_rd_req    (i_rd_req),
        .i_rd_idx    (i_rd_idx),
        .o_rd_vld    (o_rd_vld),
        .o_rd_data   (o_rd_data),
        .o_rd_stage  (o_rd_stage),
        .o_multi_hit (o_multi_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        int                port;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } wb_ev_t;

    wb_ev_t evq[$];
    int     now;
    bit     exp_multi;
    bit     pend_dup;
    int     n_checks;
    int     n_pass;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        i_clr     = 1'b0;
        i_wb_vld  = '0;
        i_wb_idx  = '0;
        i_wb_data = '0;
        i_rd_req  = '0;
        i_rd_idx  = '0;
    endtask

    task automatic set_wb(input int p, input int idx, input logic [DATA_W-1:0] data);
        i_wb_vld[p]  = 1'b1;
        i_wb_idx[p]  = IDX_W'(idx);
        i_wb_data[p] = data;
    endtask

    task automatic set_rd(input int r, input int idx);
        i_rd_req[r] = 1'b1;
        i_rd_idx[r] = IDX_W'(idx);
    endtask

    task automatic model_reset();
        evq.delete();
        exp_multi = 1'b0;
    endtask

    // Compare every lookup port and the sticky flag against the model.
    task automatic model_check();
        wb_ev_t cand[$];
        int     cnt[DEPTH+1];
        int     best;
        int     age;
        bit     exp_v;
        logic [DATA_W-1:0] exp_d;
        int     exp_s;
        cand = evq;
        for (int p = 0; p < WB; p++)
            if (i_wb_vld[p]) cand.push_back('{now, p, i_wb_idx[p], i_wb_data[p]});
        pend_dup = 1'b0;
        for (int r = 0; r < RD; r++) begin
            exp_v = 1'b0; exp_d = '0; exp_s = 0;
            if (i_rd_req[r]) begin
                best = -1;
                foreach (cnt[a]) cnt[a] = 0;
                foreach (cand[i]) begin
                    age = now - cand[i].cyc;
                    if (cand[i].idx == i_rd_idx[r] && age <= DEPTH) begin
                        cnt[age]++;
                        if (best < 0 || cand[i].cyc > cand[best].cyc ||
                            (cand[i].cyc == cand[best].cyc && cand[i].port > cand[best].port))
                            best = i;
                    end
                end
                if (best >= 0) begin
                    exp_v = 1'b1;
                    exp_d = cand[best].data;
                    exp_s = now - cand[best].cyc;
                end
                foreach (cnt[a]) if (cnt[a] > 1) pend_dup = 1'b1;
            end
            check($sformatf("rd%0d_vld", r),   64'(o_rd_vld[r]),   64'(exp_v));
            check($sformatf("rd%0d_data", r),  o_rd_data[r],       exp_d);
            check($sformatf("rd%0d_stage", r), 64'(o_rd_stage[r]), 64'(exp_s));
        end
        check("multi_hit", 64'(o_multi_hit), 64'(exp_multi));
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        @(posedge clk);
        for (int p = 0; p < WB; p++)
            if (i_wb_vld[p]) evq.push_back('{now, p, i_wb_idx[p], i_wb_data[p]});
        if (i_clr) begin
            for (int i = evq.size() - 1; i >= 0; i--)
                if (evq[i].cyc < now) evq.delete(i);
        end
        if (pend_dup) exp_multi = 1'b1;
        now++;
        for (int i = evq.size() - 1; i >= 0; i--)
            if (now - evq[i].cyc > DEPTH) evq.delete(i);
        @(negedge clk);
    endtask

    task automatic step();
        model_check();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        now      = 0;
        pend_dup = 1'b0;
        model_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Lookups after reset with no writebacks must all miss.
        for (int r = 0; r < RD; r++) set_rd(r, r);
        #1;
        check("reset_vld", 64'(o_rd_vld), 64'(0));
        check("reset_multi", 64'(o_multi_hit), 64'(0));
        step();

        // Same-cycle forward.
        clear_inputs(); set_wb(0, 5, 64'hAA); set_rd(0, 5); #1;
        check("fwd0_vld", 64'(o_rd_vld[0]), 64'(1));
        check("fwd0_data", o_rd_data[0], 64'hAA);
        check("fwd0_stage", 64'(o_rd_stage[0]), 64'(0));
        step();

        // Aging through the history.
        clear_inputs(); set_wb(1, 7, 64'h11); set_rd(0, 7); #1; step();
        clear_inputs(); set_rd(2, 7); #1;
        check("age1_stage", 64'(o_rd_stage[2]), 64'(1));
        check("age1_data", o_rd_data[2], 64'h11);
        step();
        clear_inputs(); set_rd(2, 7); #1;
        check("age2_stage", 64'(o_rd_stage[2]), 64'(2));
        check("age2_data", o_rd_data[2], 64'h11);
        step();
        clear_inputs(); set_rd(2, 7); #1;
        check("age3_miss", 64'(o_rd_vld[2]), 64'(0));
        step();

        // Youngest stage has priority.
        clear_inputs(); set_wb(0, 9, 64'h1); #1; step();
        clear_inputs(); set_wb(0, 9, 64'h2); set_rd(0, 9); #1;
        check("prio_t1_data", o_rd_data[0], 64'h2);
        check("prio_t1_stage", 64'(o_rd_stage[0]), 64'(0));
        step();
        clear_inputs(); set_rd(0, 9); #1;
        check("prio_t2_data", o_rd_data[0], 64'h2);
        check("prio_t2_stage", 64'(o_rd_stage[0]), 64'(1));
        check("prio_multi", 64'(o_multi_hit), 64'(0));
        step();

        // Clear kills the older history but keeps this cycle's writebacks.
        clear_inputs(); set_wb(0, 3, 64'h33); #1; step();
        clear_inputs(); i_clr = 1'b1; set_wb(2, 4, 64'h44); set_rd(1, 3); #1;
        check("clr_presee_vld", 64'(o_rd_vld[1]), 64'(1));
        check("clr_presee_stage", 64'(o_rd_stage[1]), 64'(1));
        step();
        clear_inputs(); set_rd(0, 3); set_rd(1, 4); #1;
        check("clr_old_miss", 64'(o_rd_vld[0]), 64'(0));
        check("clr_new_vld", 64'(o_rd_vld[1]), 64'(1));
        check("clr_new_stage", 64'(o_rd_stage[1]), 64'(1));
        check("clr_new_data", o_rd_data[1], 64'h44);
        step();

        // Duplicate writers in one stage: highest port wins, flag is sticky.
        clear_inputs(); set_wb(0, 6, 64'h60); set_wb(2, 6, 64'h62); set_rd(0, 6); #1;
        check("dup_data", o_rd_data[0], 64'h62);
        check("dup_multi_pre", 64'(o_multi_hit), 64'(0));
        step();
        clear_inputs(); #1;
        check("dup_multi_t1", 64'(o_multi_hit), 64'(1));
        step();
        clear_inputs(); set_rd(0, 6); set_rd(1, 4); #1;
        check("dup_multi_t2", 64'(o_multi_hit), 64'(1));
        check("prerst_vld", 64'(o_rd_vld[0]), 64'(1));

        // Short reset pulse in the middle of a cycle.
        rst = 1'b0; #2;
        model_reset();
        check("midrst_vld", 64'(o_rd_vld), 64'(0));
        check("midrst_multi", 64'(o_multi_hit), 64'(0));
        rst = 1'b1; #1;
        step();

        // Randomized traffic with a narrow index range to force collisions.
        for (int c = 0; c < 500; c++) begin
            clear_inputs();
            for (int p = 0; p < WB; p++)
                if ($urandom_range(0, 1) == 1)
                    set_wb(p, int'($urandom_range(0, 7)), {$urandom, $urandom});
            for (int r = 0; r < RD; r++)
                if ($urandom_range(0, 3) != 0) set_rd(r, int'($urandom_range(0, 7)));
            i_clr = ($urandom_range(0, 15) == 0);
            #1;
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0; #1;
                model_reset();
                rst = 1'b1; #1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bypass_net.md
BYPASS_NET -- requirements
Module: bypass_net

Interface
REQ-001 Parameter WB_WIDTH, default 4: writeback ports per cycle.
REQ-002 Parameter RD_PORTS, default 6: operand lookup ports.
REQ-003 Parameter DEPTH, default 2: registered history stages kept after the writeback cycle; legal 1..4.
REQ-004 Clocking SHALL be one clock, and reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 i_clr  input  1  synchronous invalidate of all history entries.
REQ-008 i_wb_vld  input  WB_WIDTH  per-port writeback valid.
REQ-009 i_wb_idx  input  iprIdx_t[WB_WIDTH]  writeback physical register index.
REQ-010 i_wb_data  input  XDEF[WB_WIDTH]  writeback data.
REQ-011 i_rd_req  input  RD_PORTS  per-port lookup request.
REQ-012 i_rd_idx  input  iprIdx_t[RD_PORTS]  lookup physical register index.
REQ-013 o_rd_vld  output  RD_PORTS  lookup hit.
REQ-014 o_rd_data  output  XDEF[RD_PORTS]  forwarded data.
REQ-015 o_rd_stage  output  clog2(DEPTH+1)[RD_PORTS]  age of the hit: 0 = current cycle, k = k cycles ago.
REQ-016 o_multi_hit  output  1  sticky error flag.

Function
REQ-017 History SHALL be a DEPTH-deep shift structure; each stage holds WB_WIDTH entries of {vld, idx, data}.
REQ-018 Each cycle, stage 1 SHALL capture the current i_wb_* inputs and stage k SHALL take stage k-1 (k = 2..DEPTH); the oldest stage is discarded.
REQ-019 Stage 0 SHALL be the live i_wb_* inputs, so a lookup matches same-cycle writebacks combinationally with 0-cycle latency.
REQ-020 A port hits when i_rd_req is 1 and some valid entry in stage 0..DEPTH has idx equal to i_rd_idx.
REQ-021 Priority SHALL be youngest stage first; o_rd_stage reports the winning stage.
REQ-022 Within one stage, if more than one entry matches, the highest-numbered WB port SHALL win.
REQ-023 A same-stage multiple match with i_rd_req=1 SHALL set o_multi_hit on the next edge; it stays 1 until reset.
REQ-024 Matches in different stages SHALL NOT set o_multi_hit.
REQ-025 On a miss or when i_rd_req=0, o_rd_vld, o_rd_data and o_rd_stage SHALL all be 0.
REQ-026 Lookup outputs SHALL be purely combinational from the inputs and history; there is no request/response handshake and no backpressure.
REQ-027 i_clr=1 SHALL clear vld in stages 2..DEPTH on the next edge.
REQ-028 When i_clr=1, stage 1 SHALL still capture the current-cycle writebacks, because same-cycle writebacks are architecturally valid.
REQ-029 While i_clr=1, lookups in that same cycle SHALL still see the pre-clear history.
REQ-030 Entries with vld=0 SHALL never match, regardless of their idx and data contents.

Reset
REQ-031 While rst=0, every history vld bit and o_multi_hit SHALL clear asynchronously.
REQ-032 While rst=0, idx and data storage SHALL be don't-care.
REQ-033 After reset with no writebacks, every o_rd_vld SHALL be 0.
REQ-034 Stage-0 forwarding SHALL operate in the first cycle after reset deassertion.

Verification
REQ-035 Same-cycle forward: WB0 {idx=5, data=0xAA}, RD0 req idx=5 in the same cycle -> o_rd_vld[0]=1, data=0xAA, stage=0.
REQ-036 Aging: WB1 {idx=7, data=0x11} at cycle T only; RD port looks up idx=7 -> stage 1 at T+1 and stage 2 at T+2 (DEPTH=2), data 0x11 both times; miss at T+3.
REQ-037 Priority: idx=9 written with 0x1 at T and 0x2 at T+1; lookup at T+1 -> data 0x2, stage 0; lookup at T+2 -> data 0x2, stage 1; o_multi_hit stays 0.
REQ-038 Clear: idx=3 written at T; i_clr=1 at T+1 together with WB {idx=4, data=0x44}; at T+2 lookup idx=3 misses and idx=4 hits with stage 1 and data 0x44.
REQ-039 Duplicate: WB0 and WB2 both write idx=6 (data 0x60 and 0x62) with a lookup in the same cycle -> data 0x62; o_multi_hit=1 from the next cycle onward.
REQ-040 Reset mid-operation: history holds valid entries, rst pulsed low for a fraction of a cycle -> all lookups miss immediately and o_multi_hit=0.
